// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA timing constants for the sync generator and the renderers.
// Holds the default 640x480@60 timing, the derived totals and the
// coordinate width every consumer of hcount/vcount agrees on.
package vga_sync_gen_pkg;

    localparam int unsigned CoordW   = 11;
    localparam int unsigned MaxTotal = 2048;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;

    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DefHTotal = axis_total(DefHActive, DefHFp, DefHSync, DefHBp);
    localparam int unsigned DefVTotal = axis_total(DefVActive, DefVFp, DefVSync, DefVBp);

endpackage

// File: rtl/vga_sync_gen_axis_counter.sv
// One raster axis (horizontal or vertical).
// Ports:
//   clk, rst   - board clock, synchronous active-high reset
//   adv        - advance the counter by one on this clock
//   count      - registered position, 0..TOTAL-1
//   sync_n     - registered, low while count sits in the sync window
//   in_active  - true when the position after this clock lies in the active area
//   wrap       - advancing from TOTAL-1 back to 0 on this clock
module vga_axis_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned ACTIVE = DefHActive,
    parameter int unsigned FP     = DefHFp,
    parameter int unsigned SYNC   = DefHSync,
    parameter int unsigned BP     = DefHBp
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [CoordW-1:0] count,
    output logic              sync_n,
    output logic              in_active,
    output logic              wrap
);

    localparam int unsigned Total = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CoordW-1:0] LastCount = CoordW'(Total - 1);
    localparam logic [CoordW-1:0] SyncFirst = CoordW'(ACTIVE + FP);
    localparam logic [CoordW-1:0] SyncLast  = CoordW'(ACTIVE + FP + SYNC - 1);
    localparam logic [CoordW-1:0] ActiveEnd = CoordW'(ACTIVE);

    logic [CoordW-1:0] count_q, count_d;
    logic              sync_n_q, sync_n_d;

    always_comb begin
        wrap    = adv && (count_q == LastCount);
        count_d = count_q;
        if (adv) begin
            count_d = wrap ? '0 : count_q + CoordW'(1);
        end
        // Decoded from the next position so sync lands on the same edge as the count.
        sync_n_d  = !((count_d >= SyncFirst) && (count_d <= SyncLast));
        in_active = (count_d < ActiveEnd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            sync_n_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count  = count_q;
    assign sync_n = sync_n_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator.
// Divides the board clock down to the pixel rate and produces the raster
// position plus registered sync/blank, all changing together on the edge that
// ends a pixel period.
// Ports:
//   clk, rst          - board clock, synchronous active-high reset
//   hcount, vcount    - current pixel column / line
//   hsync, vsync      - sync outputs at SYNC_POL level when asserted
//   blank             - high outside the active area
//   pix_tick          - high on the last clock of each pixel period
//   frame_tick        - high on the last clock of the last pixel of a frame
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [CoordW-1:0] hcount,
    output logic [CoordW-1:0] vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              pix_tick,
    output logic              frame_tick
);

    localparam int unsigned HTotal = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned VTotal = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DivW   = $clog2(CLK_DIV);

    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_sync_gen: CLK_DIV must be in 2..16");
    end
    if (HTotal > MaxTotal) begin : g_bad_h_total
        $error("vga_sync_gen: horizontal total exceeds 2048");
    end
    if (VTotal > MaxTotal) begin : g_bad_v_total
        $error("vga_sync_gen: vertical total exceeds 2048");
    end

    logic [DivW-1:0] div_q, div_d;
    logic            blank_q, blank_d;

    logic h_sync_n, h_in_active, h_wrap;
    logic v_sync_n, v_in_active, v_wrap;

    always_comb begin
        pix_tick = (div_q == DivLast);
        div_d    = pix_tick ? '0 : div_q + DivW'(1);
        blank_d  = !(h_in_active && v_in_active);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            blank_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            blank_q <= blank_d;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .adv       (pix_tick),
        .count     (hcount),
        .sync_n    (h_sync_n),
        .in_active (h_in_active),
        .wrap      (h_wrap)
    );

    // The vertical axis steps once per completed line.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .adv       (h_wrap),
        .count     (vcount),
        .sync_n    (v_sync_n),
        .in_active (v_in_active),
        .wrap      (v_wrap)
    );

    // Internal sync is active-low; flip it when an active-high polarity is requested.
    assign hsync      = h_sync_n ^ SYNC_POL;
    assign vsync      = v_sync_n ^ SYNC_POL;
    assign blank      = blank_q;
    // Vertical wrap already implies pix_tick at the last column of the last line.
    assign frame_tick = v_wrap;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        pix;
        logic        frame;
    } obs_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b, hcount_c, vcount_c;
    logic hsync_a, vsync_a, blank_a, pix_a, frame_a;
    logic hsync_b, vsync_b, blank_b, pix_b, frame_b;
    logic hsync_c, vsync_c, blank_c, pix_c, frame_c;

    obs_t obs_a, obs_b, obs_c;
    assign obs_a = {hcount_a, vcount_a, hsync_a, vsync_a, blank_a, pix_a, frame_a};
    assign obs_b = {hcount_b, vcount_b, hsync_b, vsync_b, blank_b, pix_b, frame_b};
    assign obs_c = {hcount_c, vcount_c, hsync_c, vsync_c, blank_c, pix_c, frame_c};

    int checks = 0;
    int errors = 0;

    // Clocks elapsed since each DUT last sampled reset high.
    longint n_a = 0, n_b = 0, n_c = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
        n_c <= rst_c ? 0 : n_c + 1;
    end

    // Default timing.
    vga_sync_gen u_dut_a (
        .clk(clk), .rst(rst_a), .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a),
        .vsync(vsync_a), .blank(blank_a), .pix_tick(pix_a), .frame_tick(frame_a)
    );

    // Small override, active-high sync.
    vga_sync_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b),
        .vsync(vsync_b), .blank(blank_b), .pix_tick(pix_b), .frame_tick(frame_b)
    );

    // Mid-size timing with an odd divider for randomized reset stress.
    vga_sync_gen #(
        .CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
    ) u_dut_c (
        .clk(clk), .rst(rst_c), .hcount(hcount_c), .vcount(vcount_c), .hsync(hsync_c),
        .vsync(vsync_c), .blank(blank_c), .pix_tick(pix_c), .frame_tick(frame_c)
    );

    // Closed-form raster: pixel index = clocks / divider, then column/line by division.
    function automatic obs_t model(input longint n, input longint cd,
                                   input longint ha, input longint hf, input longint hsy,
                                   input longint hb, input longint va, input longint vf,
                                   input longint vsy, input longint vb, input bit pol);
        obs_t   o;
        longint ht = ha + hf + hsy + hb;
        longint vt = va + vf + vsy + vb;
        longint p  = n / cd;
        longint h  = p % ht;
        longint v  = (p / ht) % vt;
        o.h     = h[10:0];
        o.v     = v[10:0];
        o.hs    = (h >= ha + hf && h < ha + hf + hsy) ? pol : ~pol;
        o.vs    = (v >= va + vf && v < va + vf + vsy) ? pol : ~pol;
        o.blank = (h >= ha) || (v >= va);
        o.pix   = (n % cd) == cd - 1;
        o.frame = o.pix && (h == ht - 1) && (v == vt - 1);
        return o;
    endfunction

    function automatic obs_t model_a(input longint n);
        return model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    endfunction
    function automatic obs_t model_b(input longint n);
        return model(n, 2, 8, 1, 2, 1, 4, 1, 1, 1, 1'b1);
    endfunction
    function automatic obs_t model_c(input longint n);
        return model(n, 3, 20, 3, 5, 4, 10, 2, 2, 3, 1'b0);
    endfunction

    task automatic test_reset();
        obs_t ra = '{h: 11'd0, v: 11'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, pix: 1'b0, frame: 1'b0};
        obs_t rb = '{h: 11'd0, v: 11'd0, hs: 1'b0, vs: 1'b0, blank: 1'b0, pix: 1'b0, frame: 1'b0};
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs_a !== ra) begin
                errors++; $display("FAIL reset_hold_a cyc=%0d got %h want %h", i, obs_a, ra);
            end
            checks++;
            if (obs_b !== rb) begin
                errors++; $display("FAIL reset_hold_b cyc=%0d got %h want %h", i, obs_b, rb);
            end
            checks++;
            if (obs_c !== ra) begin
                errors++; $display("FAIL reset_hold_c cyc=%0d got %h want %h", i, obs_c, ra);
            end
        end
    endtask

    task automatic test_release();
        obs_t exp;
        rst_a = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (pix_a !== (k == 3 ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL release_pix clk=%0d got %b want %b", k, pix_a, k == 3);
            end
            checks++;
            if (hcount_a !== (k >= 4 ? 11'd1 : 11'd0)) begin
                errors++; $display("FAIL release_hcount clk=%0d got %0d", k, hcount_a);
            end
            exp = model_a(n_a);
            checks++;
            if (obs_a !== exp) begin
                errors++; $display("FAIL release_model n=%0d got %h want %h", n_a, obs_a, exp);
            end
        end
    endtask

    task automatic test_line_scan();
        obs_t prev = obs_a;
        obs_t exp;
        int   hs_low = 0;
        int   blank_hi = 0;
        bit   wrapped = 1'b0;
        for (int i = 0; i < 4000 && !wrapped; i++) begin
            @(negedge clk);
            exp = model_a(n_a);
            checks++;
            if (obs_a !== exp) begin
                errors++; $display("FAIL line_scan n=%0d got %h want %h", n_a, obs_a, exp);
            end
            if (obs_a.v == 11'd0) begin
                if (!obs_a.hs) hs_low++;
                if (obs_a.blank) blank_hi++;
            end
            if (prev.h == 11'd799 && obs_a.h == 11'd0) begin
                wrapped = 1'b1;
                checks++;
                if (prev.v !== 11'd0 || obs_a.v !== 11'd1) begin
                    errors++;
                    $display("FAIL line_wrap got v %0d->%0d want 0->1", prev.v, obs_a.v);
                end
            end
            prev = obs_a;
        end
        checks++;
        if (!wrapped) begin
            errors++; $display("FAIL line_wrap_seen got 0 want 1");
        end
        checks++;
        if (hs_low != 384) begin
            errors++; $display("FAIL hsync_low_clocks got %0d want 384", hs_low);
        end
        checks++;
        if (blank_hi != 640) begin
            errors++; $display("FAIL blank_clocks got %0d want 640", blank_hi);
        end
    endtask

    task automatic test_mid_reset();
        obs_t ra = '{h: 11'd0, v: 11'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, pix: 1'b0, frame: 1'b0};
        obs_t exp;
        bit   found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            if (obs_a.h == 11'd300 && obs_a.v == 11'd1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_reset_reach got h=%0d v=%0d want 300,1", hcount_a, vcount_a);
        end
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        checks++;
        if (obs_a !== ra) begin
            errors++; $display("FAIL mid_reset_values got %h want %h", obs_a, ra);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (hcount_a !== 11'd0 || vcount_a !== 11'd0) begin
                errors++; $display("FAIL mid_reset_hold clk=%0d got h=%0d v=%0d want 0,0",
                                   k, hcount_a, vcount_a);
            end
        end
        @(negedge clk);
        checks++;
        if (hcount_a !== 11'd1) begin
            errors++; $display("FAIL mid_reset_resume got h=%0d want 1", hcount_a);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            exp = model_a(n_a);
            checks++;
            if (obs_a !== exp) begin
                errors++; $display("FAIL mid_reset_model n=%0d got %h want %h", n_a, obs_a, exp);
            end
        end
    endtask

    task automatic test_override_frame();
        obs_t   exp;
        int     ticks = 0;
        int     vs_hi = 0;
        longint first_n = -1;
        longint last_n = -1;
        rst_b = 1'b0;
        for (int i = 0; i < 504; i++) begin
            @(negedge clk);
            exp = model_b(n_b);
            checks++;
            if (obs_b !== exp) begin
                errors++; $display("FAIL override n=%0d got %h want %h", n_b, obs_b, exp);
            end
            if (obs_b.vs) vs_hi++;
            if (obs_b.frame) begin
                ticks++;
                if (first_n < 0) first_n = n_b;
                last_n = n_b;
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++; $display("FAIL override_frame_ticks got %0d want 3", ticks);
        end
        checks++;
        if (last_n - first_n != 336) begin
            errors++; $display("FAIL override_frame_spacing got %0d want 336", last_n - first_n);
        end
        checks++;
        if (vs_hi != 72) begin
            errors++; $display("FAIL override_vsync_clocks got %0d want 72", vs_hi);
        end
    endtask

    task automatic test_random_reset();
        obs_t exp;
        int   hold = 0;
        int   got_frames = 0;
        int   exp_frames = 0;
        rst_c = 1'b0;
        for (int i = 0; i < 9000; i++) begin
            @(negedge clk);
            exp = model_c(n_c);
            checks++;
            if (obs_c !== exp) begin
                errors++; $display("FAIL random_reset n=%0d got %h want %h", n_c, obs_c, exp);
            end
            if (obs_c.frame) got_frames++;
            if (exp.frame) exp_frames++;
            if (rst_c) begin
                if (hold == 0) rst_c = 1'b0;
                else hold--;
            end else if ($urandom_range(0, 2999) == 0) begin
                rst_c = 1'b1;
                hold  = int'($urandom_range(0, 10));
            end
        end
        checks++;
        if (got_frames != exp_frames) begin
            errors++; $display("FAIL random_frames got %0d want %0d", got_frames, exp_frames);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_line_scan();
        test_mid_reset();
        test_override_frame();
        test_random_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
